exc_unit: RTL and testbench
===========================

Name: exc_unit

Overview:
- Trap controller that sits directly upstream of the CSR block.
- Collects synchronous exception flags from the retire stage, synchronizes external interrupt lines, arbitrates priority and sequences trap entry and MRET.
- Drives the CSR block's exception write-back bus: we_exc, is_int, sel_exc_nret, mcause/mepc/mtval/mstatus/mip data.
- Drives flush/stall/redirect to the pipeline.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the interrupt-line synchronizers (min 2).
INT_MASK, 3'b111, per-source enable {MEI, MTI, MSI}; masked sources never become pending.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
valid_i  in  1  retire-stage instruction valid
pc_i  in  32  PC of retiring instruction
inst_i  in  32  retiring instruction word
addr_i  in  32  fault address: jump/branch target or load/store effective address
e_inst_misaligned_i  in  1  instruction-address misaligned
e_illegal_inst_i  in  1  decoder illegal instruction
e_illegal_inst_csr_i  in  1  illegal CSR access from the CSR block
e_ecall_i  in  1  ECALL
e_ebreak_i  in  1  EBREAK
e_load_misaligned_i  in  1  load misaligned
e_store_misaligned_i  in  1  store misaligned
mret_i  in  1  MRET retiring
ext_int_i, tmr_int_i, sw_int_i  in  1 each  asynchronous interrupt lines
mie_i  in  32  current mie CSR
mstatus_i  in  32  current mstatus CSR
exc_ret_addr_i  in  32  CSR return/vector address (mepc when sel_exc_nret_o=1, else mtvec)
we_exc_o  out  1  CSR exception write strobe
is_int_o  out  1  interrupt-taken strobe
sel_exc_nret_o  out  1  1 selects mepc, 0 selects mtvec
mcause_o, mepc_o, mtval_o, mstatus_o, mip_o  out  32 each  CSR write data
flush_o  out  1  kill younger instructions
stall_o  out  1  hold fetch/retire
redirect_o  out  1  PC <= exc_ret_addr_i this cycle

Behaviour:
- Reset: all outputs 0; FSM to IDLE; synchronizers cleared. Async assertion aborts any sequence immediately, with no partial CSR write.
- All outputs are registered.
- Interrupt synchronization:
  - Each line passes through a SYNC_STAGES-deep synchronizer, ANDed with INT_MASK.
  - mip_o[11]=MEIP, mip_o[7]=MTIP, mip_o[3]=MSIP; all other bits 0. mip_o updates every cycle.
- Interrupt taken when: state IDLE, valid_i=1, mstatus_i[3]=1, and (mip & mie_i) nonzero.
  - Priority: MEI(11) > MSI(3) > MTI(7).
  - An interrupt beats any synchronous exception in the same cycle.
- Synchronous exception priority (valid_i=1 required):
  - inst misaligned(0) > illegal (either flag, 2) > ebreak(3) > ecall(11) > load misaligned(4) > store misaligned(6).
  - mret_i with any exception flag: the exception wins.
- FSM states IDLE, TRAP, RET_RD, RET_WR.
- IDLE:
  - On an event, latch cause/pc/tval/mstatus. Go to TRAP for a trap, RET_RD for MRET; otherwise stay in IDLE.
  - flush_o=stall_o=redirect_o=0 in IDLE.
- TRAP (1 cycle):
  - we_exc_o=1, sel_exc_nret_o=0, flush_o=1, redirect_o=1; is_int_o=1 for interrupts.
  - mcause_o = {int, 27'b0, code}.
  - mepc_o = {latched pc[31:2], 2'b00}.
  - mtval_o: addr_i for misaligned fetch/load/store, inst_i for illegal, pc_i for ebreak, 0 for ecall and interrupts.
  - mstatus_o = latched mstatus with MPIE[7]<=MIE[3], MIE[3]<=0, MPP[12:11]<=2'b11.
  - Next state: IDLE.
- RET_RD (1 cycle): sel_exc_nret_o=1, stall_o=1, flush_o=1, no write. Samples exc_ret_addr_i as mepc.
- RET_WR (1 cycle):
  - we_exc_o=1, sel_exc_nret_o=1, redirect_o=1.
  - mepc_o = sampled mepc; mcause_o/mtval_o = last values driven in TRAP.
  - mstatus_o = MIE<=MPIE, MPIE<=1, MPP<=11.
  - Next state: IDLE.
- Latency:
  - Trap: event in cycle N -> write/redirect in N+1.
  - MRET: event in N -> redirect in N+2.
- stall_o=1 in every non-IDLE state. New events in non-IDLE states are ignored.
- valid_i=0: no event is accepted; interrupts remain pending.

Test Plan:
- Illegal instruction, pc_i=0x100, inst_i=0xFFFFFFFF, mstatus_i=0x8 -> next cycle: we_exc_o=1, mcause_o=2, mepc_o=0x100, mtval_o=0xFFFFFFFF, mstatus_o=0x1880, redirect_o=1, sel_exc_nret_o=0.
- ext_int_i=1 with mie_i=0x800, mstatus_i=0x8, valid_i=1, plus e_ecall_i -> after SYNC_STAGES+1 cycles: is_int_o=1, mcause_o=0x8000000B, mtval_o=0.
- mret_i, mstatus_i=0x1880, exc_ret_addr_i=0x104 in RET_RD -> RET_WR: mepc_o=0x104, mstatus_o=0x1888, redirect_o=1 two cycles after mret.
- Load misaligned and ebreak together, addr_i=0x2001 -> mcause_o=3, mtval_o=pc_i.
- Interrupt pending but mstatus_i[3]=0, or valid_i=0 -> no trap; mip_o still reflects the synchronized lines.
- rst_i low during RET_RD -> all outputs 0 at once; after release, FSM in IDLE and no we_exc_o pulse.

Source files
------------

// File: rtl/exc_unit.sv
// ---------------------------------------------------------------------------
// exc_unit -- machine-mode trap controller in front of the CSR block.
//
// Collects synchronous exception flags from the retire stage, synchronizes
// the three external interrupt lines, picks the highest-priority event and
// sequences trap entry (IDLE->TRAP->IDLE) and MRET (IDLE->RET_RD->RET_WR->IDLE).
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-low reset
//   valid_i, pc_i, inst_i, addr_i retiring instruction and its fault address
//   e_*_i, mret_i                exception / MRET flags of the retiring instr
//   ext_int_i/tmr_int_i/sw_int_i asynchronous interrupt lines
//   mie_i, mstatus_i             current CSR values
//   exc_ret_addr_i               mepc (sel_exc_nret_o=1) or mtvec (=0)
//   we_exc_o, is_int_o, sel_exc_nret_o, mcause_o, mepc_o, mtval_o,
//   mstatus_o, mip_o             CSR exception write-back bus
//   flush_o, stall_o, redirect_o pipeline control
//   dbg_state_o                  current FSM state (debug observation)
//
// Handshake: valid_i has no ready partner. An event is accepted only in IDLE
// on a cycle with valid_i=1; stall_o=1 marks every cycle in which events are
// ignored, so the retire stage must hold its instruction while stall_o=1.
// ---------------------------------------------------------------------------
module exc_unit #(
  parameter int         SYNC_STAGES = 2,       // synchronizer depth, min 2
  parameter logic [2:0] INT_MASK    = 3'b111   // {MEI, MTI, MSI} enables
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] addr_i,
  input  logic        e_inst_misaligned_i,
  input  logic        e_illegal_inst_i,
  input  logic        e_illegal_inst_csr_i,
  input  logic        e_ecall_i,
  input  logic        e_ebreak_i,
  input  logic        e_load_misaligned_i,
  input  logic        e_store_misaligned_i,
  input  logic        mret_i,
  input  logic        ext_int_i,
  input  logic        tmr_int_i,
  input  logic        sw_int_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] exc_ret_addr_i,
  output logic        we_exc_o,
  output logic        is_int_o,
  output logic        sel_exc_nret_o,
  output logic [31:0] mcause_o,
  output logic [31:0] mepc_o,
  output logic [31:0] mtval_o,
  output logic [31:0] mstatus_o,
  output logic [31:0] mip_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRAP   = 2'd1,
    S_RET_RD = 2'd2,
    S_RET_WR = 2'd3
  } state_e;

  state_e                       state_q;
  // The first SYNC_STAGES-1 synchronizer flops live here; mip_o is the last
  // stage, so the value that drives arbitration is the value seen on mip_o.
  logic [SYNC_STAGES-2:0][2:0]  sync_q;
  logic [2:0]                   sync_last;
  logic [31:0]                  ms_lat_q;   // mstatus captured at MRET

  logic [31:0] pend;
  logic        int_take;
  logic [3:0]  int_code;
  logic        exc_take;
  logic [3:0]  exc_code;
  logic [31:0] exc_tval;
  logic        ret_take;
  logic [31:0] trap_ms;
  logic [31:0] ret_ms;

  assign sync_last   = sync_q[SYNC_STAGES-2] & INT_MASK;
  assign dbg_state_o = state_q;

  always_comb begin
    pend     = mip_o & mie_i;
    int_take = valid_i && mstatus_i[3] && (|pend);
    // MEI > MSI > MTI
    if (pend[11])     int_code = 4'd11;
    else if (pend[3]) int_code = 4'd3;
    else              int_code = 4'd7;

    exc_take = 1'b1;
    exc_code = 4'd0;
    exc_tval = 32'd0;
    if (e_inst_misaligned_i) begin
      exc_code = 4'd0;  exc_tval = addr_i;
    end else if (e_illegal_inst_i || e_illegal_inst_csr_i) begin
      exc_code = 4'd2;  exc_tval = inst_i;
    end else if (e_ebreak_i) begin
      exc_code = 4'd3;  exc_tval = pc_i;
    end else if (e_ecall_i) begin
      exc_code = 4'd11; exc_tval = 32'd0;
    end else if (e_load_misaligned_i) begin
      exc_code = 4'd4;  exc_tval = addr_i;
    end else if (e_store_misaligned_i) begin
      exc_code = 4'd6;  exc_tval = addr_i;
    end else begin
      exc_take = 1'b0;
    end
    exc_take = exc_take && valid_i;
    ret_take = valid_i && mret_i;

    // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M
    trap_ms        = mstatus_i;
    trap_ms[7]     = mstatus_i[3];
    trap_ms[3]     = 1'b0;
    trap_ms[12:11] = 2'b11;

    // MRET: MIE<=MPIE, MPIE<=1, MPP<=M
    ret_ms         = ms_lat_q;
    ret_ms[3]      = ms_lat_q[7];
    ret_ms[7]      = 1'b1;
    ret_ms[12:11]  = 2'b11;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q        <= S_IDLE;
      sync_q         <= '0;
      ms_lat_q       <= '0;
      we_exc_o       <= 1'b0;
      is_int_o       <= 1'b0;
      sel_exc_nret_o <= 1'b0;
      mcause_o       <= '0;
      mepc_o         <= '0;
      mtval_o        <= '0;
      mstatus_o      <= '0;
      mip_o          <= '0;
      flush_o        <= 1'b0;
      stall_o        <= 1'b0;
      redirect_o     <= 1'b0;
    end else begin
      sync_q[0] <= {ext_int_i, tmr_int_i, sw_int_i};
      for (int i = 1; i < SYNC_STAGES - 1; i++) sync_q[i] <= sync_q[i-1];
      mip_o <= {20'd0, sync_last[2], 3'd0, sync_last[1], 3'd0, sync_last[0], 3'd0};

      // Control strobes are single-cycle; data buses hold until rewritten
      // so RET_WR can replay the cause/tval of the last trap.
      we_exc_o       <= 1'b0;
      is_int_o       <= 1'b0;
      sel_exc_nret_o <= 1'b0;
      flush_o        <= 1'b0;
      stall_o        <= 1'b0;
      redirect_o     <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (int_take || exc_take) begin
            state_q    <= S_TRAP;
            we_exc_o   <= 1'b1;
            is_int_o   <= int_take;
            flush_o    <= 1'b1;
            stall_o    <= 1'b1;
            redirect_o <= 1'b1;
            mcause_o   <= int_take ? {1'b1, 27'd0, int_code} : {1'b0, 27'd0, exc_code};
            mepc_o     <= {pc_i[31:2], 2'b00};
            mtval_o    <= int_take ? 32'd0 : exc_tval;
            mstatus_o  <= trap_ms;
          end else if (ret_take) begin
            state_q        <= S_RET_RD;
            ms_lat_q       <= mstatus_i;
            sel_exc_nret_o <= 1'b1;
            flush_o        <= 1'b1;
            stall_o        <= 1'b1;
          end
        end
        S_TRAP: state_q <= S_IDLE;
        S_RET_RD: begin
          // CSR block presents mepc on exc_ret_addr_i during this cycle.
          state_q        <= S_RET_WR;
          we_exc_o       <= 1'b1;
          sel_exc_nret_o <= 1'b1;
          stall_o        <= 1'b1;
          redirect_o     <= 1'b1;
          mepc_o         <= exc_ret_addr_i;
          mstatus_o      <= ret_ms;
        end
        S_RET_WR: state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exc_unit.sv
// ---------------------------------------------------------------------------
// tb_exc_unit -- self-checking bench for exc_unit: table of directed trap
// vectors, hand-written interrupt/MRET/reset sequences, and a randomized
// phase checked against an event-level reference model with a write queue.
// ---------------------------------------------------------------------------
module tb_exc_unit;
  localparam int SYNC = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, mret_i;
  logic [31:0] pc_i, inst_i, addr_i, mie_i, mstatus_i, exc_ret_addr_i;
  logic [6:0]  flags;   // {inst_mis, illegal, illegal_csr, ebreak, ecall, load_mis, store_mis}
  logic [2:0]  lines;   // {ext, tmr, sw}
  logic        e_inst_misaligned_i, e_illegal_inst_i, e_illegal_inst_csr_i;
  logic        e_ecall_i, e_ebreak_i, e_load_misaligned_i, e_store_misaligned_i;
  logic        ext_int_i, tmr_int_i, sw_int_i;
  logic        we_exc_o, is_int_o, sel_exc_nret_o, flush_o, stall_o, redirect_o;
  logic [31:0] mcause_o, mepc_o, mtval_o, mstatus_o, mip_o;
  logic [1:0]  dbg_state_o;

  assign {e_inst_misaligned_i, e_illegal_inst_i, e_illegal_inst_csr_i, e_ebreak_i,
          e_ecall_i, e_load_misaligned_i, e_store_misaligned_i} = flags;
  assign {ext_int_i, tmr_int_i, sw_int_i} = lines;

  exc_unit #(.SYNC_STAGES(SYNC), .INT_MASK(3'b111)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .pc_i(pc_i), .inst_i(inst_i),
    .addr_i(addr_i), .e_inst_misaligned_i(e_inst_misaligned_i),
    .e_illegal_inst_i(e_illegal_inst_i), .e_illegal_inst_csr_i(e_illegal_inst_csr_i),
    .e_ecall_i(e_ecall_i), .e_ebreak_i(e_ebreak_i),
    .e_load_misaligned_i(e_load_misaligned_i), .e_store_misaligned_i(e_store_misaligned_i),
    .mret_i(mret_i), .ext_int_i(ext_int_i), .tmr_int_i(tmr_int_i), .sw_int_i(sw_int_i),
    .mie_i(mie_i), .mstatus_i(mstatus_i), .exc_ret_addr_i(exc_ret_addr_i),
    .we_exc_o(we_exc_o), .is_int_o(is_int_o), .sel_exc_nret_o(sel_exc_nret_o),
    .mcause_o(mcause_o), .mepc_o(mepc_o), .mtval_o(mtval_o), .mstatus_o(mstatus_o),
    .mip_o(mip_o), .flush_o(flush_o), .stall_o(stall_o), .redirect_o(redirect_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [128:0] exp_q[$];   // {is_int, mcause, mepc, mtval, mstatus}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0;
    flags   = '0;
    mret_i  = 1'b0;
  endtask

  function automatic logic [5:0] ctrl_now();
    return {we_exc_o, is_int_o, sel_exc_nret_o, flush_o, stall_o, redirect_o};
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_trap_ms(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (m[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction

  function automatic logic [31:0] m_ret_ms(input logic [31:0] m);
    return (m & ~32'h0000_1888) | (m[7] ? 32'h8 : 32'h0) | 32'h80 | 32'h1800;
  endfunction

  // Highest-priority synchronous exception -> cause code and trap value.
  task automatic m_exc(input logic [6:0] f, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] addr, output logic [31:0] code, output logic [31:0] tval);
    if (f[6])             begin code = 0;  tval = addr; end
    else if (f[5] | f[4]) begin code = 2;  tval = inst; end
    else if (f[3])        begin code = 3;  tval = pc;   end
    else if (f[2])        begin code = 11; tval = 0;    end
    else if (f[1])        begin code = 4;  tval = addr; end
    else                  begin code = 6;  tval = addr; end
  endtask

  // Expected control strobes for each abstract phase.
  // 0 idle, 1 trap write, 2 mret read, 3 mret write
  function automatic logic [5:0] m_ctrl(input int phase);
    case (phase)
      1:       return 6'b100111;
      2:       return 6'b001110;
      3:       return 6'b101011;
      default: return 6'b000000;
    endcase
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        valid;
    logic [6:0]  f;
    logic        mret;
    logic [31:0] pc, inst, addr, ms;
    logic        exp_we;
    logic [31:0] exp_cause, exp_mepc, exp_mtval, exp_ms;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [31:0] code, tval;
    logic [128:0] rec;
    logic [6:0] rf;
    int phase, nxt;
    logic [31:0] m_cause, m_tval, m_ms;

    tbl[0] = '{1'b1, 7'b0100000, 1'b0, 32'h100, 32'hFFFF_FFFF, 32'h0,    32'h8,
               1'b1, 32'd2,  32'h100, 32'hFFFF_FFFF, 32'h1880};
    tbl[1] = '{1'b1, 7'b0001010, 1'b0, 32'h200, 32'h13,        32'h2001, 32'h0,
               1'b1, 32'd3,  32'h200, 32'h200,       32'h1800};
    tbl[2] = '{1'b1, 7'b1100000, 1'b0, 32'h300, 32'h0,         32'h3002, 32'h88,
               1'b1, 32'd0,  32'h300, 32'h3002,      32'h1880};
    tbl[3] = '{1'b1, 7'b0000110, 1'b0, 32'h403, 32'h73,        32'h4001, 32'hFFFF_FFFF,
               1'b1, 32'd11, 32'h400, 32'h0,         32'hFFFF_FFF7};
    tbl[4] = '{1'b1, 7'b0000001, 1'b0, 32'h500, 32'h0,         32'h5005, 32'h80,
               1'b1, 32'd6,  32'h500, 32'h5005,      32'h1800};
    tbl[5] = '{1'b1, 7'b0010000, 1'b0, 32'h600, 32'h3020_0073, 32'h0,    32'h0,
               1'b1, 32'd2,  32'h600, 32'h3020_0073, 32'h1800};
    tbl[6] = '{1'b0, 7'b0100000, 1'b0, 32'h700, 32'hFFFF_FFFF, 32'h0,    32'h8,
               1'b0, 32'd0,  32'h0,   32'h0,         32'h0};
    tbl[7] = '{1'b1, 7'b0000011, 1'b0, 32'h800, 32'h0,         32'h8002, 32'h8,
               1'b1, 32'd4,  32'h800, 32'h8002,      32'h1880};
    tbl[8] = '{1'b1, 7'b0001000, 1'b1, 32'h904, 32'h0010_0073, 32'h0,    32'h8,
               1'b1, 32'd3,  32'h904, 32'h904,       32'h1880};
    tbl[9] = '{1'b1, 7'b0000000, 1'b0, 32'hA00, 32'h0,         32'h0,    32'h8,
               1'b0, 32'd0,  32'h0,   32'h0,         32'h0};

    // ---- reset state ----
    rst_i = 1'b0;
    idle_inputs();
    lines = 3'b000;
    pc_i = 0; inst_i = 0; addr_i = 0; mie_i = 0; mstatus_i = 0; exc_ret_addr_i = 0;
    repeat (2) tick();
    chk("reset_ctrl", {26'd0, ctrl_now()}, 32'd0);
    chk("reset_mcause", mcause_o, 32'd0);
    chk("reset_mstatus", mstatus_o, 32'd0);
    chk("reset_mip", mip_o, 32'd0);
    chk("reset_state", {30'd0, dbg_state_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // ---- table-driven synchronous exceptions ----
    for (int i = 0; i < 10; i++) begin
      valid_i = tbl[i].valid; flags = tbl[i].f; mret_i = tbl[i].mret;
      pc_i = tbl[i].pc; inst_i = tbl[i].inst; addr_i = tbl[i].addr; mstatus_i = tbl[i].ms;
      tick();
      chk($sformatf("tbl%0d_we", i), {31'd0, we_exc_o}, {31'd0, tbl[i].exp_we});
      if (tbl[i].exp_we) begin
        chk($sformatf("tbl%0d_mcause", i), mcause_o, tbl[i].exp_cause);
        chk($sformatf("tbl%0d_mepc", i), mepc_o, tbl[i].exp_mepc);
        chk($sformatf("tbl%0d_mtval", i), mtval_o, tbl[i].exp_mtval);
        chk($sformatf("tbl%0d_mstatus", i), mstatus_o, tbl[i].exp_ms);
        chk($sformatf("tbl%0d_ctrl", i), {26'd0, ctrl_now()}, 32'b100111);
      end else begin
        chk($sformatf("tbl%0d_ctrl", i), {26'd0, ctrl_now()}, 32'd0);
      end
      idle_inputs();
      tick();
      chk($sformatf("tbl%0d_back_idle", i), {26'd0, ctrl_now()}, 32'd0);
    end

    // ---- MRET sequence (events during RET_RD are ignored) ----
    valid_i = 1'b1; mret_i = 1'b1; mstatus_i = 32'h1880;
    tick();
    chk("mret_rd_ctrl", {26'd0, ctrl_now()}, 32'b001110);
    idle_inputs();
    valid_i = 1'b1; flags = 7'b0100000; mstatus_i = 32'h8;
    exc_ret_addr_i = 32'h104;
    tick();
    chk("mret_wr_ctrl", {26'd0, ctrl_now()}, 32'b101011);
    chk("mret_wr_mepc", mepc_o, 32'h104);
    chk("mret_wr_mstatus", mstatus_o, 32'h1888);
    chk("mret_wr_mcause_kept", mcause_o, 32'd3);
    chk("mret_wr_mtval_kept", mtval_o, 32'h904);
    idle_inputs();
    tick();
    chk("mret_done_ctrl", {26'd0, ctrl_now()}, 32'd0);

    // ---- interrupt sync latency, interrupt beats ecall ----
    mie_i = 32'h800; mstatus_i = 32'h8; pc_i = 32'hC00;
    lines = 3'b100;
    repeat (SYNC - 1) tick();
    chk("int_sync_early", mip_o, 32'h0);
    tick();
    chk("int_sync_mip", mip_o, 32'h800);
    valid_i = 1'b1; flags = 7'b0000100;
    tick();
    chk("int_ext_ctrl", {26'd0, ctrl_now()}, 32'b110111);
    chk("int_ext_mcause", mcause_o, 32'h8000_000B);
    chk("int_ext_mtval", mtval_o, 32'h0);
    chk("int_ext_mepc", mepc_o, 32'hC00);
    idle_inputs();
    tick();

    // ---- interrupt priority MEI > MSI > MTI ----
    mie_i = 32'h888;
    for (int k = 0; k < 3; k++) begin
      logic [2:0]  l;
      logic [31:0] ec, em;
      l  = (k == 0) ? 3'b111 : (k == 1) ? 3'b011 : 3'b010;
      ec = (k == 0) ? 32'h8000_000B : (k == 1) ? 32'h8000_0003 : 32'h8000_0007;
      em = (k == 0) ? 32'h888 : (k == 1) ? 32'h088 : 32'h080;
      lines = l;
      repeat (SYNC) tick();
      chk($sformatf("prio%0d_mip", k), mip_o, em);
      valid_i = 1'b1;
      tick();
      chk($sformatf("prio%0d_mcause", k), mcause_o, ec);
      chk($sformatf("prio%0d_is_int", k), {31'd0, is_int_o}, 32'd1);
      idle_inputs();
      tick();
    end

    // ---- interrupt gated by MIE, valid_i and mie_i; stays pending ----
    lines = 3'b010; mie_i = 32'h80; mstatus_i = 32'h0; valid_i = 1'b1;
    repeat (SYNC) tick();
    chk("gate_mie0_we", {31'd0, we_exc_o}, 32'd0);
    chk("gate_mie0_mip", mip_o, 32'h80);
    mstatus_i = 32'h8; valid_i = 1'b0;
    tick();
    chk("gate_valid0_we", {31'd0, we_exc_o}, 32'd0);
    mie_i = 32'h800; valid_i = 1'b1;
    tick();
    chk("gate_mie_mismatch_we", {31'd0, we_exc_o}, 32'd0);
    mie_i = 32'h80;
    tick();
    chk("gate_pending_taken", {26'd0, ctrl_now()}, 32'b110111);
    chk("gate_pending_mcause", mcause_o, 32'h8000_0007);
    idle_inputs();
    lines = 3'b000;
    repeat (SYNC + 2) tick();

    // ---- async reset during RET_RD ----
    valid_i = 1'b1; mret_i = 1'b1; mstatus_i = 32'h1880;
    tick();
    chk("rst_pre_ctrl", {26'd0, ctrl_now()}, 32'b001110);
    idle_inputs();
    rst_i = 1'b0;
    #2;
    chk("rst_async_ctrl", {26'd0, ctrl_now()}, 32'd0);
    chk("rst_async_data", mcause_o | mepc_o | mtval_o | mstatus_o | mip_o, 32'd0);
    chk("rst_async_state", {30'd0, dbg_state_o}, 32'd0);
    #1;
    rst_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_after%0d_we", k), {31'd0, we_exc_o}, 32'd0);
      chk($sformatf("rst_after%0d_state", k), {30'd0, dbg_state_o}, 32'd0);
    end

    // ---- randomized phase against the event model ----
    phase = 0; m_cause = 0; m_tval = 0; m_ms = 0;
    for (int i = 0; i < 300; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      for (int b = 0; b < 7; b++) rf[b] = ($urandom_range(0, 7) == 0);
      flags = rf;
      mret_i = ($urandom_range(0, 4) == 0);
      pc_i = $urandom; inst_i = $urandom; addr_i = $urandom;
      mstatus_i = $urandom; mie_i = $urandom; exc_ret_addr_i = $urandom;

      nxt = 0;
      if (phase == 0) begin
        if (valid_i && (|flags)) begin
          m_exc(flags, pc_i, inst_i, addr_i, code, tval);
          m_cause = code; m_tval = tval;
          exp_q.push_back({1'b0, code, pc_i & 32'hFFFF_FFFC, tval, m_trap_ms(mstatus_i)});
          nxt = 1;
        end else if (valid_i && mret_i) begin
          m_ms = mstatus_i;
          nxt = 2;
        end
      end else if (phase == 2) begin
        exp_q.push_back({1'b0, m_cause, exc_ret_addr_i, m_tval, m_ret_ms(m_ms)});
        nxt = 3;
      end
      tick();
      chk("rnd_ctrl", {26'd0, ctrl_now()}, {26'd0, m_ctrl(nxt)});
      if (we_exc_o) begin
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_write", 32'd1, 32'd0);
        end else begin
          rec = exp_q.pop_front();
          chk("rnd_is_int", {31'd0, is_int_o}, {31'd0, rec[128]});
          chk("rnd_mcause", mcause_o, rec[127:96]);
          chk("rnd_mepc", mepc_o, rec[95:64]);
          chk("rnd_mtval", mtval_o, rec[63:32]);
          chk("rnd_mstatus", mstatus_o, rec[31:0]);
        end
      end
      phase = nxt;
    end
    idle_inputs();
    repeat (3) tick();
    chk("rnd_writes_drained", exp_q.size(), 32'd0);

    // ---- report ----
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
